piton_core_rst_irq_ctrl: RTL and testbench
==========================================

// Module: piton_core_rst_irq_ctrl
// PURPOSE
// Parametrised core reset-release and interrupt-synchronisation front end for a CVA6 tile in OpenPiton.
// Holds the core in reset while tile SRAMs initialise, then optionally waits for an L15 wake-up interrupt.
// Supports a software-requested warm reset of the core without repeating the SRAM wait.
// Synchronises N platform interrupt lines plus ipi/timer/debug, gated off while the core is in reset.
// PARAMETERS
// NrIrq          2      number of level-sensitive irq lines (mip/sip...), >=1
// SyncStages     2      flop stages per synchroniser (reset and interrupts), >=2
// WakeCycles     32768  cycles spent in INIT before leaving it, >=1
// WakeOnInt      0      1: after INIT also wait for an L15 wake interrupt (wake_val_i)
// SoftRstCycles  16     cycles the core reset stays asserted for a soft reset, >=1
// PORTS
// clk_i           in   1           core clock
// reset_l         in   1           tile reset, asynchronous, active-low
// wake_val_i      in   1           L15 interrupt-return valid carrying a wake-up (sync to clk_i)
// soft_rst_req_i  in   1           warm-reset request pulse/level (sync to clk_i)
// irq_i           in   NrIrq       async level interrupts
// ipi_i           in   1           async inter-processor interrupt
// time_irq_i      in   1           async timer interrupt
// debug_req_i     in   1           async debug request
// core_rst_no     out  1           core reset, active-low, to core rst_ni
// irq_o           out  NrIrq       synchronised, gated irq_i
// ipi_o           out  1           synchronised, gated ipi_i
// time_irq_o      out  1           synchronised, gated time_irq_i
// debug_req_o     out  1           synchronised, gated debug_req_i
// state_o         out  2           FSM state: 0 INIT, 1 WAKE, 2 RUN, 3 SOFT
// BEHAVIOUR
// - Reset: clock is clk_i; reset is reset_l, asynchronous, active-low. All flops clear asynchronously:
//   state=INIT, cnt=0, wake_seen=0, and every synchroniser stage=0. All outputs are 0.
// - cnt width: $clog2(max(WakeCycles,SoftRstCycles)+1).
// - INIT: cnt+1 per cycle. When cnt==WakeCycles-1:
//   - goes to WAKE if WakeOnInt=1 and wake_seen=0 and wake_val_i=0;
//   - otherwise goes to RUN. cnt then clears.
// - wake_seen: sticky; set by wake_val_i in any state before RUN; cleared on entering RUN.
//   A wake arriving early is therefore never lost.
// - WAKE: goes to RUN on the first cycle with wake_val_i=1. Stays in WAKE indefinitely otherwise.
// - RUN: soft_rst_req_i=1 -> SOFT, cnt=0.
// - SOFT: cnt+1 per cycle; goes to RUN when cnt==SoftRstCycles-1.
//   soft_rst_req_i=1 while in SOFT restarts cnt at 0 (the reset extends).
//   The SRAM wait and the wake wait are not repeated.
// - soft_rst_req_i in INIT or WAKE is ignored.
// - core_rst_no: the value (state==RUN) is passed through a SyncStages-deep flop chain.
//   - Release: rises exactly SyncStages cycles after the edge on which state becomes RUN.
//   - Assertion on reset_l low: falls asynchronously and immediately.
//   - Assertion on entering SOFT: falls SyncStages cycles after entering SOFT.
//   - Total latency from reset_l rising to core_rst_no rising is WakeCycles+SyncStages cycles
//     when WakeOnInt=0.
// - Interrupts: each input goes through its own SyncStages-deep synchroniser.
//   Each output = sync_out & core_rst_no, so all interrupt outputs are 0 whenever the core is in reset.
//   Latency is SyncStages cycles from a stable input level. Inputs are levels: no edge capture or stretching.
// - state_o is the registered FSM state.
// TESTING
// - Params WakeCycles=8, SyncStages=2, WakeOnInt=0. Release reset_l -> state_o=RUN at cycle 8,
//   core_rst_no=1 at cycle 10, never earlier.
// - WakeOnInt=1, no wake. Release reset -> state_o=1 (WAKE) from cycle 8 and core_rst_no stays 0.
//   Pulse wake_val_i at cycle 20 -> RUN at cycle 21, core_rst_no=1 at cycle 23.
// - WakeOnInt=1, wake_val_i pulsed at cycle 3 (during INIT) -> state goes straight to RUN at cycle 8,
//   and the WAKE state is never visited.
// - In RUN, SoftRstCycles=16, pulse soft_rst_req_i -> core_rst_no low for 16 cycles then high.
//   Repeat with a second pulse at SOFT cnt=10 -> reset low period extends by 11 cycles.
// - Hold irq_i=2'b11 and debug_req_i=1 from reset release -> outputs stay 0 until core_rst_no=1,
//   then go high. Drop irq_i[0] -> irq_o[0] falls 2 cycles later.
// - Drop reset_l mid-SOFT and mid-RUN -> core_rst_no and all interrupt outputs go 0 immediately,
//   state_o=0, and the full INIT sequence repeats after release.

Source files
------------

// File: rtl/piton_core_rst_irq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piton_core_rst_irq_ctrl : CVA6 tile core-reset release and irq synchroniser
// Revision: 1.0
// ----------------------------------------------------------------------------
module piton_core_rst_irq_ctrl #(
  parameter int NrIrq         = 2,
  parameter int SyncStages    = 2,
  parameter int WakeCycles    = 32768,
  parameter bit WakeOnInt     = 1'b0,
  parameter int SoftRstCycles = 16
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             wake_val_i,
  input  logic             soft_rst_req_i,
  input  logic [NrIrq-1:0] irq_i,
  input  logic             ipi_i,
  input  logic             time_irq_i,
  input  logic             debug_req_i,
  output logic             core_rst_no,
  output logic [NrIrq-1:0] irq_o,
  output logic             ipi_o,
  output logic             time_irq_o,
  output logic             debug_req_o,
  output logic [1:0]       state_o
);

  localparam int MaxCycles = (WakeCycles > SoftRstCycles) ? WakeCycles : SoftRstCycles;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam int IrqW      = NrIrq + 3;
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] SoftLast = CntW'(SoftRstCycles - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2,
    SOFT = 2'd3
  } state_t;

  state_t                          state, state_nxt;
  logic [CntW-1:0]                 cnt, cnt_nxt;
  logic                            wake_seen, wake_seen_nxt;
  logic [SyncStages-1:0]           rst_sync;
  logic [SyncStages-1:0][IrqW-1:0] irq_sync;
  logic [IrqW-1:0]                 irq_gated;

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state     <= INIT;
      cnt       <= '0;
      wake_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wake_seen <= wake_seen_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wake_seen_nxt = wake_seen;
    unique case (state)
      INIT: begin
        wake_seen_nxt = wake_seen | wake_val_i;
        if (cnt == WakeLast) begin
          cnt_nxt = '0;
          if (WakeOnInt && !wake_seen && !wake_val_i) state_nxt = WAKE;
          else                                        state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAKE: begin
        wake_seen_nxt = wake_seen | wake_val_i;
        if (wake_val_i) state_nxt = RUN;
      end
      RUN: begin
        if (soft_rst_req_i) begin
          state_nxt = SOFT;
          cnt_nxt   = '0;
        end
      end
      SOFT: begin
        // A repeated request restarts the count, stretching the warm reset.
        if (soft_rst_req_i) begin
          cnt_nxt = '0;
        end else if (cnt == SoftLast) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
    if (state_nxt == RUN && state != RUN) wake_seen_nxt = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      rst_sync <= '0;
      irq_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SyncStages-2:0], state == RUN};
      irq_sync <= {irq_sync[SyncStages-2:0], {irq_i, ipi_i, time_irq_i, debug_req_i}};
    end
  end

  // Interrupts are masked whenever the core is held in reset.
  assign core_rst_no = rst_sync[SyncStages-1];
  assign irq_gated   = irq_sync[SyncStages-1] & {IrqW{core_rst_no}};
  assign {irq_o, ipi_o, time_irq_o, debug_req_o} = irq_gated;
  assign state_o     = state;

endmodule
`default_nettype wire

// File: tb/tb_piton_core_rst_irq_ctrl.sv
`default_nettype none
// tb_piton_core_rst_irq_ctrl : two builds (WakeOnInt 0/1) checked each cycle
// against a countdown/queue reference model, plus directed timing checks.
module tb_piton_core_rst_irq_ctrl;

  localparam int NrIrq         = 2;
  localparam int SyncStages    = 2;
  localparam int WakeCycles    = 8;
  localparam int SoftRstCycles = 16;
  localparam int IrqW          = NrIrq + 3;

  logic             clk      = 1'b0;
  logic             reset_l  = 1'b0;
  logic             wake_val = 1'b0;
  logic             soft_req = 1'b0;
  logic [NrIrq-1:0] irq      = '0;
  logic             ipi      = 1'b0;
  logic             tirq     = 1'b0;
  logic             dbg      = 1'b0;

  logic             rst0, rst1, ipi0, ipi1, tim0, tim1, dbg0, dbg1;
  logic [NrIrq-1:0] irq0, irq1;
  logic [1:0]       st0, st1;

  always #5 clk = ~clk;

  piton_core_rst_irq_ctrl #(
    .NrIrq(NrIrq), .SyncStages(SyncStages), .WakeCycles(WakeCycles),
    .WakeOnInt(1'b0), .SoftRstCycles(SoftRstCycles)
  ) u_dut0 (
    .clk_i(clk), .reset_l(reset_l), .wake_val_i(wake_val), .soft_rst_req_i(soft_req),
    .irq_i(irq), .ipi_i(ipi), .time_irq_i(tirq), .debug_req_i(dbg),
    .core_rst_no(rst0), .irq_o(irq0), .ipi_o(ipi0), .time_irq_o(tim0),
    .debug_req_o(dbg0), .state_o(st0)
  );

  piton_core_rst_irq_ctrl #(
    .NrIrq(NrIrq), .SyncStages(SyncStages), .WakeCycles(WakeCycles),
    .WakeOnInt(1'b1), .SoftRstCycles(SoftRstCycles)
  ) u_dut1 (
    .clk_i(clk), .reset_l(reset_l), .wake_val_i(wake_val), .soft_rst_req_i(soft_req),
    .irq_i(irq), .ipi_i(ipi), .time_irq_i(tirq), .debug_req_i(dbg),
    .core_rst_no(rst1), .irq_o(irq1), .ipi_o(ipi1), .time_irq_o(tim1),
    .debug_req_o(dbg1), .state_o(st1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase per build, remaining-cycle countdowns, delay queues.
  int              m_state   [2];
  int              init_left [2];
  int              soft_left [2];
  bit              wake_seen [2];
  logic [1:0]      rh [$];
  logic [IrqW-1:0] ih [$];
  logic [1:0]      exp_rst;
  logic [IrqW-1:0] exp_sync;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d]   = 0;
      init_left[d] = WakeCycles;
      soft_left[d] = 0;
      wake_seen[d] = 1'b0;
    end
    rh.delete();
    ih.delete();
    repeat (SyncStages - 1) begin
      rh.push_back(2'b00);
      ih.push_back('0);
    end
    exp_rst  = 2'b00;
    exp_sync = '0;
  endtask

  task automatic model_step();
    logic [1:0] run_pre;
    for (int d = 0; d < 2; d++) run_pre[d] = (m_state[d] == 2);
    rh.push_back(run_pre);
    exp_rst = rh.pop_front();
    ih.push_back({irq, ipi, tirq, dbg});
    exp_sync = ih.pop_front();
    for (int d = 0; d < 2; d++) begin
      case (m_state[d])
        0: begin
          wake_seen[d] = wake_seen[d] | wake_val;
          init_left[d] = init_left[d] - 1;
          if (init_left[d] == 0) m_state[d] = (d == 1 && !wake_seen[d]) ? 1 : 2;
        end
        1: if (wake_val) m_state[d] = 2;
        2: if (soft_req) begin
          m_state[d]   = 3;
          soft_left[d] = SoftRstCycles;
        end
        default: begin
          if (soft_req) soft_left[d] = SoftRstCycles;
          else begin
            soft_left[d] = soft_left[d] - 1;
            if (soft_left[d] == 0) m_state[d] = 2;
          end
        end
      endcase
      if (m_state[d] == 2) wake_seen[d] = 1'b0;
    end
  endtask

  always @(negedge reset_l) model_reset();
  always @(posedge clk) if (reset_l) model_step();

  task automatic compare_all();
    check("state0", 32'(st0), 32'(m_state[0]));
    check("state1", 32'(st1), 32'(m_state[1]));
    check("rst0", 32'(rst0), 32'(exp_rst[0]));
    check("rst1", 32'(rst1), 32'(exp_rst[1]));
    check("irq0", 32'({irq0, ipi0, tim0, dbg0}), 32'(exp_sync & {IrqW{exp_rst[0]}}));
    check("irq1", 32'({irq1, ipi1, tim1, dbg1}), 32'(exp_sync & {IrqW{exp_rst[1]}}));
  endtask

  int n = 0;

  task automatic cycle();
    @(negedge clk);
    n++;
    compare_all();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_l = 1'b1;
    n = 0;
  endtask

  task automatic async_drop();
    #2 reset_l = 1'b0;
    #1 compare_all();
  endtask

  int first0, first1, wake_cnt, low0, low1;

  initial begin
    model_reset();
    #1 compare_all();
    repeat (3) cycle();

    // Release with irq/debug held high; build 1 waits for a wake at cycle 20.
    irq = 2'b11;
    dbg = 1'b1;
    release_reset();
    first0 = -1; first1 = -1; wake_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (rst0 && first0 < 0) first0 = n;
      if (rst1 && first1 < 0) first1 = n;
      if (st1 == 2'd1) wake_cnt++;
      wake_val = (n == 20);
      if (n == 25) irq[0] = 1'b0;
    end
    check("rel0_cycle", 32'(first0), 32'(WakeCycles + SyncStages));
    check("wake_cycles", 32'(wake_cnt), 32'd13);
    check("rel1_cycle", 32'(first1), 32'd23);

    // Reset mid-RUN; early wake during INIT must skip WAKE.
    async_drop();
    repeat (2) cycle();
    release_reset();
    first1 = -1; wake_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (rst1 && first1 < 0) first1 = n;
      if (st1 == 2'd1) wake_cnt++;
      wake_val = (n == 3);
    end
    check("early_wake_visits", 32'(wake_cnt), 32'd0);
    check("early_wake_rel", 32'(first1), 32'(WakeCycles + SyncStages));

    // Single soft reset, then one extended at SOFT count 10.
    soft_req = 1'b1;
    low0 = 0; low1 = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      soft_req = 1'b0;
      {irq, ipi, tirq, dbg} = IrqW'($urandom);
      if (!rst0) low0++;
      if (!rst1) low1++;
    end
    check("soft_low0", 32'(low0), 32'(SoftRstCycles));
    check("soft_low1", 32'(low1), 32'(SoftRstCycles));
    soft_req = 1'b1;
    low0 = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      soft_req = (i == 10);
      {irq, ipi, tirq, dbg} = IrqW'($urandom);
      if (!rst0) low0++;
    end
    check("soft_ext_low0", 32'(low0), 32'(SoftRstCycles + 11));

    // Reset dropped in the middle of SOFT.
    soft_req = 1'b1;
    cycle();
    soft_req = 1'b0;
    repeat (5) cycle();
    async_drop();
    repeat (2) cycle();
    release_reset();

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(0, 3) == 0) {irq, ipi, tirq, dbg} = IrqW'($urandom);
      soft_req = ($urandom_range(0, 19) == 0);
      wake_val = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 249) == 0) begin
        async_drop();
        repeat ($urandom_range(1, 3)) cycle();
        release_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
